// File: rtl/scatter_gather_pkg.sv
// -----------------------------------------------------------------------------
// scatter_gather_pkg
//   Types and helpers shared by the tile/network serializers (scatter_io now,
//   gather_io later).
//   word_t     : one channel word, `QW bits
//   vec_t      : one tile vector, `XW channel words packed, channel i at [i]
//   chan_cnt_w : width of a channel counter for n channels, never below 1 bit
// -----------------------------------------------------------------------------
`ifndef QW
`define QW 16
`endif
`ifndef XW
`define XW 128
`endif

package scatter_gather_pkg;

    typedef logic [`QW-1:0] word_t;
    typedef word_t [`XW-1:0] vec_t;

    function automatic int chan_cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vec_pingpong.sv
// -----------------------------------------------------------------------------
// vec_pingpong
//   Two-slot vector buffer. The writer hands over a whole vector in one
//   handshake; the reader sees the oldest slot in full and frees it with a
//   single release pulse once it is done with it.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   wr_vec_i      : incoming vector, channels >= N are ignored
//   wr_valid_i    : incoming vector valid
//   wr_ready_o    : a slot is free (low while rst is high)
//   rd_vec_o      : contents of the oldest occupied slot
//   rd_valid_o    : at least one slot occupied (low while rst is high)
//   rd_release_i  : reader is finished with the oldest slot
// -----------------------------------------------------------------------------
module vec_pingpong
    import scatter_gather_pkg::*;
#(
    parameter int N = 128
) (
    input  logic  clk,
    input  logic  rst,
    input  vec_t  wr_vec_i,
    input  logic  wr_valid_i,
    output logic  wr_ready_o,
    output word_t rd_vec_o [N],
    output logic  rd_valid_o,
    input  logic  rd_release_i
);

    word_t      slot_q [2][N];
    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       acc, rel;

    // Channels above N are never stored; folding them here keeps them
    // visibly consumed for every N.
    logic       unused_chans;
    assign unused_chans = ^wr_vec_i;

    assign wr_ready_o = ~rst & (cnt_q != 2'd2);
    assign rd_valid_o = ~rst & (cnt_q != 2'd0);
    assign acc        = wr_valid_i & wr_ready_o;
    assign rel        = rd_release_i & rd_valid_o;
    assign rd_vec_o   = slot_q[rptr_q];

    // A release frees its slot only at the edge, so with both slots full the
    // writer stays blocked for that cycle and acc/rel never collide at cnt=2.
    always_comb begin
        cnt_d  = cnt_q;
        wptr_d = wptr_q ^ acc;
        rptr_d = rptr_q ^ rel;
        case ({acc, rel})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Slot storage carries no reset: contents only matter once cnt says so.
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int i = 0; i < N; i++) begin
                slot_q[wptr_q][i] <= wr_vec_i[i];
            end
        end
    end

endmodule

// File: rtl/scatter_io.sv
// -----------------------------------------------------------------------------
// scatter_io
//   Tile-to-network serializer. Accepts one vector of channel words from the
//   tile and emits channels 0..valid_chans-1 on the network link, one word per
//   cycle, lowest channel first. A two-slot buffer lets the tile hand over the
//   next vector while the current one is still being sent.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   tl_data_i   : tile vector (channels >= valid_chans ignored)
//   tl_valid_i  : tile vector valid
//   tl_ready_o  : a buffer slot is free
//   nw_data_o   : serialized channel word
//   nw_valid_o  : nw_data_o valid
//   nw_last_o   : word is the final channel of its vector
//   nw_ready_i  : network accepts the word
// -----------------------------------------------------------------------------
module scatter_io
    import scatter_gather_pkg::*;
#(
    parameter int valid_chans = 128
) (
    input  logic  clk,
    input  logic  rst,
    input  vec_t  tl_data_i,
    input  logic  tl_valid_i,
    output logic  tl_ready_o,
    output word_t nw_data_o,
    output logic  nw_valid_o,
    output logic  nw_last_o,
    input  logic  nw_ready_i
);

    localparam int                OCNT_W   = chan_cnt_w(valid_chans);
    localparam logic [OCNT_W-1:0] LAST_IDX = OCNT_W'(valid_chans - 1);

    generate
        if (valid_chans < 1 || valid_chans > `XW) begin : g_bad_chans
            $error("scatter_io: valid_chans=%0d outside 1..%0d", valid_chans, `XW);
        end
    endgenerate

    word_t             slot_vec [valid_chans];
    logic              slot_valid;
    logic              word_hs;
    logic              at_last;
    logic              vec_done;
    logic [OCNT_W-1:0] ocnt_q, ocnt_d;

    vec_pingpong #(
        .N (valid_chans)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .wr_vec_i     (tl_data_i),
        .wr_valid_i   (tl_valid_i),
        .wr_ready_o   (tl_ready_o),
        .rd_vec_o     (slot_vec),
        .rd_valid_o   (slot_valid),
        .rd_release_i (vec_done)
    );

    assign nw_valid_o = slot_valid;
    assign at_last    = (ocnt_q == LAST_IDX);
    assign nw_last_o  = nw_valid_o & at_last;
    assign word_hs    = nw_valid_o & nw_ready_i;
    assign vec_done   = word_hs & at_last;

    // A single-channel vector has no channel index to decode.
    generate
        if (valid_chans == 1) begin : g_mux_one
            assign nw_data_o = slot_vec[0];
        end else begin : g_mux_many
            assign nw_data_o = slot_vec[ocnt_q];
        end
    endgenerate

    always_comb begin
        ocnt_d = ocnt_q;
        if (word_hs) begin
            ocnt_d = at_last ? '0 : ocnt_q + OCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ocnt_q <= '0;
        end else begin
            ocnt_q <= ocnt_d;
        end
    end

endmodule
